mips_multicycle_ctrl: RTL and testbench

Multicycle control FSM for the 32-bit MIPS core: sequences one shared ALU, one unified instruction/data memory port and the register file across several clock cycles per instruction. It replaces the single-cycle main decoder in the multicycle build; the existing ALU decoder still consumes `alu_op` and funct. Supports R-type, lw, sw, beq, addi and j, plus a memory wait handshake.

---
 rtl/mips_ctrl_pkg.sv | 57 +++++
 rtl/mips_multicycle_ctrl_if.sv | 37 +++
 rtl/mc_ctrl_outputs.sv | 96 +++++++++
 rtl/mips_multicycle_ctrl.sv | 80 ++++++++
 tb/tb_mips_multicycle_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control FSM.
// Holds the opcode values, the 4-bit state encoding and the datapath mux/ALU codes
// that the controller drives. It also holds a helper that reports whether an opcode
// is one the controller can execute.
package mips_ctrl_pkg;

    // Opcodes (instruction bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // FSM state encoding
    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11,
        StJump   = 4'd12
    } ctrl_state_e;

    // alu_op codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // alu_src_b codes
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // pc_src codes
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic opcode_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle controller and the datapath/memory.
// The master modport belongs to the controller. It takes the opcode, the ALU zero flag
// and the memory ready flag, and it drives every control strobe and mux select.
// The slave modport is the datapath view of the same bus.
interface mips_multicycle_ctrl_if;

    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op
    );

endinterface

// File: rtl/mc_ctrl_outputs.sv
// Combinational control-word decoder for the multicycle MIPS controller.
// Ports:
//   state      in   current FSM state
//   mem_ready  in   memory completed this cycle (used only in FETCH)
//   zero       in   ALU zero flag (used only in BRANCH)
//   others     out  datapath control word; every field is 0 unless the state asserts it
module mc_ctrl_outputs
    import mips_ctrl_pkg::*;
(
    input  ctrl_state_e state,
    input  logic        mem_ready,
    input  logic        zero,
    output logic        mem_req,
    output logic        iord,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        pc_en
);

    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        pc_en      = 1'b0;

        unique case (state)
            StFetch: begin
                // PC+4 is written back on the same cycle the instruction lands
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_src    = PCSRC_ALU;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            StDecode: begin
                // Speculatively compute the branch target into ALUOut
                alu_src_b = SRCB_IMM_SH2;
            end
            StMemAdr, StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            StMemRd: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            StAluWb: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_en     = zero;
            end
            StAddiWb: begin
                reg_write = 1'b1;
            end
            StJump: begin
                pc_src = PCSRC_JUMP;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle control FSM for the 32-bit MIPS core.
// The controller sequences the shared ALU, the unified memory port and the register file
// for R-type, lw, sw, beq, addi and j. It stalls in FETCH, MEMRD and MEMWR until mem_ready.
// Ports:
//   clk    in       rising-edge clock
//   rst_n  in       asynchronous active-low reset; forces IDLE and thus an all-zero control word
//   bus    master   opcode/zero/mem_ready in, control word and illegal_op out
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    mips_multicycle_ctrl_if.master bus
);

    ctrl_state_e state_q, state_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  state_d = bus.mem_ready ? StDecode : StFetch;
            StDecode: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_RTYPE:     state_d = StExec;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_J:         state_d = StJump;
                    default:      state_d = StFetch;
                endcase
            end
            // Only lw and sw reach MEMADR, so anything that is not lw is a store
            StMemAdr: state_d = (bus.opcode == OP_LW) ? StMemRd : StMemWr;
            StMemRd:  state_d = bus.mem_ready ? StMemWb : StMemRd;
            StMemWb:  state_d = StFetch;
            StMemWr:  state_d = bus.mem_ready ? StFetch : StMemWr;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StAddiEx: state_d = StAddiWb;
            StAddiWb: state_d = StFetch;
            StJump:   state_d = StFetch;
            default:  state_d = StIdle;
        endcase
    end

    // Output logic
    mc_ctrl_outputs u_outputs (
        .state      (state_q),
        .mem_ready  (bus.mem_ready),
        .zero       (bus.zero),
        .mem_req    (bus.mem_req),
        .iord       (bus.iord),
        .mem_write  (bus.mem_write),
        .ir_write   (bus.ir_write),
        .reg_dst    (bus.reg_dst),
        .mem_to_reg (bus.mem_to_reg),
        .reg_write  (bus.reg_write),
        .alu_src_a  (bus.alu_src_a),
        .alu_src_b  (bus.alu_src_b),
        .alu_op     (bus.alu_op),
        .pc_src     (bus.pc_src),
        .pc_en      (bus.pc_en)
    );

    // DECODE lasts one cycle, so this is a single-cycle pulse per bad instruction
    assign bus.illegal_op = (state_q == StDecode) && !opcode_legal(bus.opcode);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    logic clk;
    logic rst_n;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    // Field order: req iord mw irw rdst m2r rw srca srcb[2] aop[2] psrc[2] pen ill
    function automatic logic [15:0] mk(input logic req, input logic iord, input logic mw,
                                       input logic irw, input logic rdst, input logic m2r,
                                       input logic rw, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] aop, input logic [1:0] psrc,
                                       input logic pen, input logic ill);
        return {req, iord, mw, irw, rdst, m2r, rw, sa, sb, aop, psrc, pen, ill};
    endfunction

    function automatic logic [15:0] observed();
        return {bus.mem_req, bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst,
                bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_src, bus.pc_en, bus.illegal_op};
    endfunction

    logic [15:0] e_zero, e_fetch, e_fetch_w, e_dec, e_dec_ill, e_adr, e_memrd, e_memwb;
    logic [15:0] e_memwr, e_exec, e_aluwb, e_br1, e_br0, e_addiwb, e_jump;

    task automatic compare_head();
        logic [15:0] e;
        logic [15:0] o;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, o, e);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check at the falling edge
    task automatic step(input string tag, input logic [15:0] e, input logic rdy,
                        input logic z);
        bus.mem_ready = rdy;
        bus.zero      = z;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        compare_head();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [15:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        compare_head();
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        e_zero    = '0;
        e_fetch   = mk(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 0);
        e_fetch_w = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
        e_dec     = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
        e_dec_ill = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 1);
        e_adr     = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
        e_memrd   = mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        e_memwb   = mk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        e_memwr   = mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        e_exec    = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
        e_aluwb   = mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        e_br1     = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0);
        e_br0     = mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 0);
        e_addiwb  = mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0);
        e_jump    = mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);

        // Reset held for 3 cycles with random inputs
        rst_n = 1'b0;
        bus.opcode = 6'($urandom);
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            bus.opcode = 6'($urandom);
            step("reset", e_zero, rb(), rb());
        end
        rst_n = 1'b1;
        bus.opcode = 6'b100011;
        step("idle", e_zero, 1'b1, rb());

        // lw, no waits, with one fetch wait first
        step("lw_fetch_wait", e_fetch_w, 1'b0, rb());
        step("lw_fetch", e_fetch, 1'b1, rb());
        step("lw_decode", e_dec, rb(), rb());
        step("lw_memadr", e_adr, rb(), rb());
        step("lw_memrd", e_memrd, 1'b1, rb());
        step("lw_memwb", e_memwb, rb(), rb());

        // sw with two wait cycles in MEMWR
        bus.opcode = 6'b101011;
        step("sw_fetch", e_fetch, 1'b1, rb());
        step("sw_decode", e_dec, rb(), rb());
        step("sw_memadr", e_adr, rb(), rb());
        step("sw_memwr_w1", e_memwr, 1'b0, rb());
        step("sw_memwr_w2", e_memwr, 1'b0, rb());
        step("sw_memwr", e_memwr, 1'b1, rb());

        // R-type
        bus.opcode = 6'b000000;
        step("r_fetch", e_fetch, 1'b1, rb());
        step("r_decode", e_dec, rb(), rb());
        step("r_exec", e_exec, rb(), rb());
        step("r_aluwb", e_aluwb, rb(), rb());

        // addi
        bus.opcode = 6'b001000;
        step("addi_fetch", e_fetch, 1'b1, rb());
        step("addi_decode", e_dec, rb(), rb());
        step("addi_ex", e_adr, rb(), rb());
        step("addi_wb", e_addiwb, rb(), rb());

        // beq taken then not taken
        bus.opcode = 6'b000100;
        step("beq1_fetch", e_fetch, 1'b1, 1'b0);
        step("beq1_decode", e_dec, rb(), 1'b0);
        step("beq1_branch", e_br1, rb(), 1'b1);
        step("beq0_fetch", e_fetch, 1'b1, 1'b1);
        step("beq0_decode", e_dec, rb(), 1'b1);
        step("beq0_branch", e_br0, rb(), 1'b0);

        // j
        bus.opcode = 6'b000010;
        step("j_fetch", e_fetch, 1'b1, rb());
        step("j_decode", e_dec, rb(), rb());
        step("j_jump", e_jump, rb(), rb());

        // Illegal opcode: pulse in DECODE, straight back to FETCH
        bus.opcode = 6'b111111;
        step("ill_fetch", e_fetch, 1'b1, rb());
        step("ill_decode", e_dec_ill, rb(), rb());
        bus.opcode = 6'b000010;
        step("ill_refetch", e_fetch, 1'b1, rb());
        step("ill_next_decode", e_dec, rb(), rb());
        step("ill_next_jump", e_jump, rb(), rb());

        // Reset during a stalled store
        bus.opcode = 6'b101011;
        step("rst_sw_fetch", e_fetch, 1'b1, rb());
        step("rst_sw_decode", e_dec, rb(), rb());
        step("rst_sw_memadr", e_adr, rb(), rb());
        step("rst_sw_memwr", e_memwr, 1'b0, rb());
        check_now("rst_sw_memwr_hold", e_memwr);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("rst_async_drop", e_zero);
        @(posedge clk);
        #1;
        step("rst_held", e_zero, 1'b0, rb());
        rst_n = 1'b1;
        bus.opcode = 6'b000000;
        step("rst_idle", e_zero, 1'b1, rb());
        step("rst_fetch", e_fetch, 1'b1, rb());
        step("rst_decode", e_dec, rb(), rb());
        step("rst_exec", e_exec, rb(), rb());

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
